// File: rtl/register_file_sb.sv
// register_file_sb: integer register file with a per-register busy
// scoreboard and a sticky halt flag for the pipelined core.
// Ports: clk, reset (sync, active-high); rs1/rs2 -> rs1_dout/rs2_dout and
//   rs1_busy/rs2_busy (combinational); alloc_en/alloc_rd mark a destination
//   busy; write_enable/rd/rd_din write back and clear busy; is_ecall checks
//   rf[HALT_IDX] against HALT_VAL to set is_halted; print_reg is a flat
//   debug copy of the register array.
// Option: define RF_BYPASS_EN for same-cycle write-to-read forwarding.
module register_file_sb #(
   parameter int XLEN = 32,
   parameter int NUM_REGS = 32,
   parameter int SP_IDX = 2,
   parameter logic [XLEN-1:0] SP_INIT = XLEN'('h2ffc),
   parameter int HALT_IDX = 17,
   parameter logic [XLEN-1:0] HALT_VAL = XLEN'(10),
   localparam int AW = $clog2(NUM_REGS)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [AW-1:0]            rs1,
   input  logic [AW-1:0]            rs2,
   output logic [XLEN-1:0]          rs1_dout,
   output logic [XLEN-1:0]          rs2_dout,
   output logic                     rs1_busy,
   output logic                     rs2_busy,
   input  logic                     alloc_en,
   input  logic [AW-1:0]            alloc_rd,
   input  logic                     write_enable,
   input  logic [AW-1:0]            rd,
   input  logic [XLEN-1:0]          rd_din,
   input  logic                     is_ecall,
   output logic                     is_halted,
   output logic [NUM_REGS*XLEN-1:0] print_reg
);

   localparam logic [AW-1:0] HALT_A = AW'(HALT_IDX);

   logic [XLEN-1:0]     rf [NUM_REGS];
   logic [NUM_REGS-1:0] busy;
   logic                wr_hit;
   logic                byp1;
   logic                byp2;
   logic                byph;
   logic [XLEN-1:0]     halt_eff;

   assign wr_hit = write_enable && (rd != '0);

`ifdef RF_BYPASS_EN
   assign byp1 = wr_hit && (rd == rs1);
   assign byp2 = wr_hit && (rd == rs2);
   assign byph = wr_hit && (rd == HALT_A);
`else
   assign byp1 = 1'b0;
   assign byp2 = 1'b0;
   assign byph = 1'b0;
`endif

   // x0 is forced to zero on the read side as well, so it never reports
   // busy nor leaks a forwarded value.
   assign rs1_dout = (rs1 == '0) ? '0 :
                     byp1 ? rd_din : rf[rs1];
   assign rs2_dout = (rs2 == '0) ? '0 :
                     byp2 ? rd_din : rf[rs2];
   assign rs1_busy = (rs1 != '0) && busy[rs1] && !byp1;
   assign rs2_busy = (rs2 != '0) && busy[rs2] && !byp2;

   // Halt sees the same value a read port would show for HALT_IDX.
   assign halt_eff = (HALT_A == '0) ? '0 :
                     byph ? rd_din : rf[HALT_A];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            rf[i] <= (i == SP_IDX) ? SP_INIT : '0;
         end
         busy      <= '0;
         is_halted <= 1'b0;
      end else begin
         if (wr_hit) begin
            rf[rd]   <= rd_din;
            busy[rd] <= 1'b0;
         end
         // Later assignment wins: a new producer allocated in the
         // writeback cycle keeps the register busy.
         if (alloc_en && (alloc_rd != '0)) begin
            busy[alloc_rd] <= 1'b1;
         end
         if (is_ecall && (halt_eff == HALT_VAL)) begin
            is_halted <= 1'b1;
         end
      end
   end

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_print
      assign print_reg[g*XLEN +: XLEN] = rf[g];
   end

endmodule
